// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 mini-router control path.
package router_pkg;

  localparam int ADDR_W    = 2;
  localparam int NUM_PORTS = 3;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

endpackage

// File: rtl/router_ctrl_fsm.sv
// Packet-sequencing controller: header decode, payload/stall/parity phase strobes,
// FIFO write enable and busy back-pressure for the 1x3 mini-router.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header with a valid address
// LOAD_FIRST_DATA    | header byte goes to the register stage (one cycle)
// LOAD_DATA          | payload bytes written to the selected FIFO
// FIFO_FULL_STATE    | selected FIFO full, writes stalled
// LOAD_AFTER_FULL    | flush the byte held during the stall
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | register stage compares parity, then clears
// WAIT_TILL_EMPTY    | destination FIFO still draining the previous packet
module router_ctrl_fsm
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [NUM_PORTS-1:0] fifo_empty, soft_reset;
  logic              empty_hdr, empty_sel, soft_sel;

  assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_reset = {soft_reset_2, soft_reset_1, soft_reset_0};

  function automatic logic pick(input logic [NUM_PORTS-1:0] vec, input logic [ADDR_W-1:0] idx);
    case (idx)
      2'd0:    pick = vec[0];
      2'd1:    pick = vec[1];
      2'd2:    pick = vec[2];
      default: pick = 1'b0;
    endcase
  endfunction

  assign empty_hdr = pick(fifo_empty, data_in);
  assign empty_sel = pick(fifo_empty, addr_q);
  assign soft_sel  = pick(soft_reset, addr_q);

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    if (soft_sel) begin
      state_n = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (pkt_valid && data_in != INVALID_ADDR) begin
            addr_n  = data_in;
            state_n = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        LOAD_FIRST_DATA: state_n = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       state_n = FIFO_FULL_STATE;
          else if (!pkt_valid) state_n = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) state_n = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        state_n = DECODE_ADDRESS;
          else if (low_pkt_valid) state_n = LOAD_PARITY;
          else                    state_n = LOAD_DATA;
        LOAD_PARITY:        state_n = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_n = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (empty_sel) state_n = LOAD_FIRST_DATA;
        default:            state_n = DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= DECODE_ADDRESS;
      addr_q        <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      addr_q        <= addr_n;
      detect_add    <= (state_n == DECODE_ADDRESS);
      lfd_state     <= (state_n == LOAD_FIRST_DATA);
      ld_state      <= (state_n == LOAD_DATA);
      laf_state     <= (state_n == LOAD_AFTER_FULL);
      full_state    <= (state_n == FIFO_FULL_STATE);
      rst_int_reg   <= (state_n == CHECK_PARITY_ERROR);
      write_enb_reg <= (state_n == LOAD_DATA) || (state_n == LOAD_PARITY) ||
                       (state_n == LOAD_AFTER_FULL);
      busy          <= !((state_n == DECODE_ADDRESS) || (state_n == LOAD_DATA));
    end
  end

endmodule
